crack_arbiter: RTL and testbench
================================

// Module: crack_arbiter
// PURPOSE
//  Downstream collector for N parallel RC4 cracking cores. Launches all cores together.
//  Watches each core's success/total_failure and latches the first winning key.
//  Broadcasts a common stop to every core, and reports result, winner index and search time.
// PARAMETERS
//  NUM_CORES    4   number of cracking cores monitored (1..16)
//  KEY_W        24  secret key width per core
//  LAUNCH_CYC   4   cycles core_reset is held high at launch (>=1)
// PORTS
//  clk                 in   1                  system clock, all logic rising-edge
//  reset               in   1                  synchronous, active-high; returns block to IDLE
//  start               in   1                  1-cycle pulse: begin (or restart) a search
//  core_success        in   NUM_CORES          per-core success level
//  core_total_failure  in   NUM_CORES          per-core keyspace-exhausted level
//  core_key            in   NUM_CORES*KEY_W    per-core current secret_key, core i at [i*KEY_W +: KEY_W]
//  core_reset          out  1                  drives every core's reset_all
//  stop                out  1                  drives every core's stop input
//  found               out  1                  search ended with a key
//  all_failed          out  1                  every core exhausted its keyspace
//  found_key           out  KEY_W              latched winning key
//  winner_idx          out  $clog2(NUM_CORES)  index of winning core
//  busy                out  1                  high in LAUNCH and SEARCH
//  cycles              out  32                 clk count spent in SEARCH, saturating
// BEHAVIOUR
//  Reset values
//   - state=IDLE; core_reset=1; stop=1; found=0; all_failed=0; busy=0.
//   - found_key=0; winner_idx=0; cycles=0; fail_seen=0.
//  FSM: IDLE -> LAUNCH -> SEARCH -> {FOUND | FAILED}. All outputs are registered.
//  IDLE
//   - core_reset=1, stop=1.
//   - start -> LAUNCH. On that edge: clear found, all_failed, cycles, fail_seen; load launch counter.
//  LAUNCH
//   - core_reset=1, stop=0, busy=1.
//   - Core status inputs are ignored (stale results from a prior run are discarded).
//   - Counter runs LAUNCH_CYC cycles, then -> SEARCH with core_reset=0.
//  SEARCH
//   - core_reset=0, stop=0, busy=1.
//   - cycles increments each clk and saturates at 32'hFFFF_FFFF.
//   - fail_seen[i] is a sticky OR of core_total_failure[i].
//   - Any core_success[i]=1 -> FOUND. Same edge: found_key<=core_key[i], winner_idx<=i.
//   - If several cores succeed in one cycle, the lowest index wins.
//   - Else if (fail_seen | core_total_failure) is all ones -> FAILED.
//   - Success beats failure in the same cycle, including when the last failing core
//     and a succeeding core coincide.
//  FOUND
//   - found=1, stop=1, core_reset=0 (cores hold decrypted RAM for inspection), busy=0.
//   - Key and index are frozen.
//  FAILED
//   - all_failed=1, stop=1, busy=0. found_key and winner_idx keep their last value.
//  start in FOUND / FAILED / SEARCH / LAUNCH
//   - Same as from IDLE: -> LAUNCH, results cleared.
//   - A start arriving in the same cycle as a success is taken as a restart; the success is dropped.
//  reset is checked before start on every edge; a reset mid-search aborts to IDLE.
//  Latency
//   - core_success edge -> found and stop high on the next clk.
//   - start -> core_reset released after LAUNCH_CYC+1 cycles.
//  core_success is level-sensitive; only the first success is recorded.
// STRUCTURE
//  Shared package crack_pkg holds:
//   - typedef enum logic [2:0] arb_state_t {IDLE, LAUNCH, SEARCH, FOUND, FAILED};
//   - localparam KEY_W_DEF = 24.
//  One sub-module, prio_enc: NUM_CORES-wide lowest-index-first encoder,
//   outputs valid and idx. Used for the success vector.
//  Everything else (FSM, counters, latches) lives in this module.
// TESTING
//  1. reset; start; after LAUNCH_CYC cycles core 2 success=1, core_key[2]=24'h00_0A5C
//     -> found=1, found_key=24'h000A5C, winner_idx=2, stop=1 next clk.
//  2. Cores 1 and 3 succeed in the same cycle -> winner_idx=1, found_key=core_key[1].
//  3. Cores 0-3 raise total_failure one at a time, 10 cycles apart
//     -> all_failed=1 only after core 3; found=0.
//  4. Cores 0-2 already failed; core 3 failure and core 0 success in the same cycle
//     -> found=1, winner_idx=0, all_failed=0.
//  5. Success held high during LAUNCH -> ignored.
//     Success after core_reset drops -> found. cycles equals SEARCH dwell.
//  6. Reset asserted mid-SEARCH -> IDLE, all outputs at reset values next clk.
//     A later start relaunches with cycles=0.

Source files
------------

// File: rtl/crack_pkg.sv
// -----------------------------------------------------------------------------
// crack_pkg
//   Shared types and defaults for the RC4 crack-core collector.
//   - arb_state_t : arbiter FSM states
//   - KEY_W_DEF   : default secret-key width per cracking core
// -----------------------------------------------------------------------------
package crack_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    SEARCH = 3'd2,
    FOUND  = 3'd3,
    FAILED = 3'd4
  } arb_state_t;

  localparam int KEY_W_DEF = 24;

endpackage

// File: rtl/prio_enc.sv
// -----------------------------------------------------------------------------
// prio_enc
//   Lowest-index-first priority encoder.
//   Ports:
//     req   in  N      request vector
//     valid out 1      at least one request bit set
//     idx   out IDX_W  index of the lowest set request bit (0 when none)
// -----------------------------------------------------------------------------
module prio_enc
  import crack_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        idx   = IDX_W'(i);
      end else begin
        valid = valid;
        idx   = idx;
      end
    end
  end

endmodule

// File: rtl/crack_arbiter.sv
// -----------------------------------------------------------------------------
// crack_arbiter
//   Collector for NUM_CORES parallel RC4 cracking cores. Launches all cores
//   together, latches the first winning key, broadcasts a common stop and
//   reports result, winner index and search time. All outputs are registered.
//   Ports:
//     clk                in  1                 rising-edge clock
//     reset              in  1                 synchronous active-high reset
//     start              in  1                 pulse: begin / restart a search
//     core_success       in  NUM_CORES         per-core success level
//     core_total_failure in  NUM_CORES         per-core keyspace-exhausted level
//     core_key           in  NUM_CORES*KEY_W   core i key at [i*KEY_W +: KEY_W]
//     core_reset         out 1                 drives every core's reset_all
//     stop               out 1                 drives every core's stop
//     found              out 1                 search ended with a key
//     all_failed         out 1                 every core exhausted its keyspace
//     found_key          out KEY_W             latched winning key
//     winner_idx         out IDX_W             index of winning core
//     busy               out 1                 high in LAUNCH and SEARCH
//     cycles             out 32                cycles spent in SEARCH, saturating
// -----------------------------------------------------------------------------
module crack_arbiter
  import crack_pkg::*;
#(
  parameter int NUM_CORES  = 4,
  parameter int KEY_W      = KEY_W_DEF,
  parameter int LAUNCH_CYC = 4,
  localparam int IDX_W     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [NUM_CORES-1:0]       core_success,
  input  logic [NUM_CORES-1:0]       core_total_failure,
  input  logic [NUM_CORES*KEY_W-1:0] core_key,
  output logic                       core_reset,
  output logic                       stop,
  output logic                       found,
  output logic                       all_failed,
  output logic [KEY_W-1:0]           found_key,
  output logic [IDX_W-1:0]           winner_idx,
  output logic                       busy,
  output logic [31:0]                cycles
);

  localparam int CNT_W = (LAUNCH_CYC > 1) ? $clog2(LAUNCH_CYC) : 1;

  arb_state_t           state_r, state_s;
  logic [CNT_W-1:0]     launch_cnt_r, launch_cnt_s;
  logic [31:0]          cycles_r, cycles_s;
  logic [NUM_CORES-1:0] fail_seen_r, fail_seen_s;
  logic [KEY_W-1:0]     found_key_r, found_key_s;
  logic [IDX_W-1:0]     winner_idx_r, winner_idx_s;
  logic                 found_r, found_s;
  logic                 all_failed_r, all_failed_s;
  logic                 core_reset_r, core_reset_s;
  logic                 stop_r, stop_s;
  logic                 busy_r, busy_s;

  logic                 win_valid_s;
  logic [IDX_W-1:0]     win_idx_s;
  logic [KEY_W-1:0]     win_key_s;
  logic                 fail_all_s;

  prio_enc #(
    .N     (NUM_CORES),
    .IDX_W (IDX_W)
  ) u_prio_enc (
    .req   (core_success),
    .valid (win_valid_s),
    .idx   (win_idx_s)
  );

  // Winning core's key and the "every core exhausted" condition for this cycle.
  always_comb begin
    win_key_s  = core_key[int'(win_idx_s) * KEY_W +: KEY_W];
    fail_all_s = &(fail_seen_r | core_total_failure);
  end

  // Next-state and next-output logic; start overrides every state.
  always_comb begin
    state_s      = state_r;
    launch_cnt_s = launch_cnt_r;
    cycles_s     = cycles_r;
    fail_seen_s  = fail_seen_r;
    found_key_s  = found_key_r;
    winner_idx_s = winner_idx_r;
    found_s      = found_r;
    all_failed_s = all_failed_r;
    core_reset_s = core_reset_r;
    stop_s       = stop_r;
    busy_s       = busy_r;

    if (start) begin
      // A start coinciding with a success is a restart; the success is dropped.
      state_s      = LAUNCH;
      launch_cnt_s = CNT_W'(LAUNCH_CYC - 1);
      cycles_s     = 32'd0;
      fail_seen_s  = '0;
      found_s      = 1'b0;
      all_failed_s = 1'b0;
      core_reset_s = 1'b1;
      stop_s       = 1'b0;
      busy_s       = 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          core_reset_s = 1'b1;
          stop_s       = 1'b1;
          busy_s       = 1'b0;
        end
        LAUNCH: begin
          // Core status is ignored here: it may be stale from a prior run.
          if (launch_cnt_r == '0) begin
            state_s      = SEARCH;
            core_reset_s = 1'b0;
          end else begin
            launch_cnt_s = launch_cnt_r - CNT_W'(1);
          end
        end
        SEARCH: begin
          if (cycles_r != 32'hFFFF_FFFF) begin
            cycles_s = cycles_r + 32'd1;
          end else begin
            cycles_s = cycles_r;
          end
          fail_seen_s = fail_seen_r | core_total_failure;
          // Success is checked first so it wins over a coincident last failure.
          if (win_valid_s) begin
            state_s      = FOUND;
            found_key_s  = win_key_s;
            winner_idx_s = win_idx_s;
            found_s      = 1'b1;
            stop_s       = 1'b1;
            busy_s       = 1'b0;
          end else if (fail_all_s) begin
            state_s      = FAILED;
            all_failed_s = 1'b1;
            stop_s       = 1'b1;
            busy_s       = 1'b0;
          end else begin
            state_s = SEARCH;
          end
        end
        FOUND: begin
          // Cores stay out of reset so their decrypted RAM can be inspected.
          core_reset_s = 1'b0;
          stop_s       = 1'b1;
          busy_s       = 1'b0;
        end
        FAILED: begin
          stop_s = 1'b1;
          busy_s = 1'b0;
        end
        default: begin
          state_s      = IDLE;
          core_reset_s = 1'b1;
          stop_s       = 1'b1;
          busy_s       = 1'b0;
        end
      endcase
    end
  end

  // State, counters and registered outputs; reset has priority over start.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      launch_cnt_r <= '0;
      cycles_r     <= 32'd0;
      fail_seen_r  <= '0;
      found_key_r  <= '0;
      winner_idx_r <= '0;
      found_r      <= 1'b0;
      all_failed_r <= 1'b0;
      core_reset_r <= 1'b1;
      stop_r       <= 1'b1;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      launch_cnt_r <= launch_cnt_s;
      cycles_r     <= cycles_s;
      fail_seen_r  <= fail_seen_s;
      found_key_r  <= found_key_s;
      winner_idx_r <= winner_idx_s;
      found_r      <= found_s;
      all_failed_r <= all_failed_s;
      core_reset_r <= core_reset_s;
      stop_r       <= stop_s;
      busy_r       <= busy_s;
    end
  end

  assign core_reset = core_reset_r;
  assign stop       = stop_r;
  assign found      = found_r;
  assign all_failed = all_failed_r;
  assign found_key  = found_key_r;
  assign winner_idx = winner_idx_r;
  assign busy       = busy_r;
  assign cycles     = cycles_r;

endmodule

// File: tb/tb_crack_arbiter.sv
// -----------------------------------------------------------------------------
// tb_crack_arbiter
//   Directed scenarios plus randomized traffic for crack_arbiter, compared
//   every cycle against a behavioural model that tracks time since launch.
// -----------------------------------------------------------------------------
module tb_crack_arbiter;

  localparam int NC = 4;
  localparam int KW = 24;
  localparam int LC = 4;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [NC-1:0]  core_success;
  logic [NC-1:0]  core_total_failure;
  logic [NC*KW-1:0] core_key;
  logic           core_reset;
  logic           stop;
  logic           found;
  logic           all_failed;
  logic [KW-1:0]  found_key;
  logic [IW-1:0]  winner_idx;
  logic           busy;
  logic [31:0]    cycles;

  int check_count = 0;
  int error_count = 0;

  // Reference model: time since launch (-1 = idle) plus result bookkeeping.
  int            m_since;
  bit            m_done;
  bit            m_found;
  bit            m_failed;
  logic [KW-1:0] m_key;
  int            m_idx;
  longint        m_cycles;
  logic [NC-1:0] m_fail_acc;

  crack_arbiter #(
    .NUM_CORES  (NC),
    .KEY_W      (KW),
    .LAUNCH_CYC (LC)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .start              (start),
    .core_success       (core_success),
    .core_total_failure (core_total_failure),
    .core_key           (core_key),
    .core_reset         (core_reset),
    .stop               (stop),
    .found              (found),
    .all_failed         (all_failed),
    .found_key          (found_key),
    .winner_idx         (winner_idx),
    .busy               (busy),
    .cycles             (cycles)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got !== exp) begin
      error_count++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs presented at that edge.
  task automatic model_edge();
    int w;
    if (reset) begin
      m_since = -1; m_done = 1'b0; m_found = 1'b0; m_failed = 1'b0;
      m_key = '0; m_idx = 0; m_cycles = 0; m_fail_acc = '0;
    end else if (start) begin
      m_since = 0; m_done = 1'b0; m_found = 1'b0; m_failed = 1'b0;
      m_cycles = 0; m_fail_acc = '0;
    end else if (m_since < 0) begin
      m_since = -1;
    end else if (m_since < LC) begin
      m_since++;
    end else if (!m_done) begin
      if (m_cycles < 64'hFFFF_FFFF) m_cycles++;
      if (core_success != '0) begin
        w = 0;
        for (int i = NC - 1; i >= 0; i--) if (core_success[i]) w = i;
        m_found = 1'b1; m_done = 1'b1; m_idx = w;
        m_key = core_key[w*KW +: KW];
      end else begin
        m_fail_acc = m_fail_acc | core_total_failure;
        if (m_fail_acc == {NC{1'b1}}) begin
          m_failed = 1'b1; m_done = 1'b1;
        end
      end
    end
  endtask

  // One clock: update model at the rising edge, compare on the falling edge.
  task automatic step();
    bit e_cr, e_stop, e_busy;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    if (m_since < 0)       begin e_cr = 1'b1; e_stop = 1'b1; e_busy = 1'b0; end
    else if (m_since < LC) begin e_cr = 1'b1; e_stop = 1'b0; e_busy = 1'b1; end
    else if (!m_done)      begin e_cr = 1'b0; e_stop = 1'b0; e_busy = 1'b1; end
    else                   begin e_cr = 1'b0; e_stop = 1'b1; e_busy = 1'b0; end
    check_value("core_reset", 32'(core_reset), 32'(e_cr));
    check_value("stop",       32'(stop),       32'(e_stop));
    check_value("busy",       32'(busy),       32'(e_busy));
    check_value("found",      32'(found),      32'(m_found));
    check_value("all_failed", 32'(all_failed), 32'(m_failed));
    check_value("found_key",  32'(found_key),  32'(m_key));
    check_value("winner_idx", 32'(winner_idx), 32'(m_idx));
    check_value("cycles",     cycles,          32'(m_cycles));
  endtask

  task automatic launch();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (LC) step();
  endtask

  task automatic random_keys();
    for (int i = 0; i < NC; i++) core_key[i*KW +: KW] = KW'($urandom);
  endtask

  initial begin
    int d;
    reset = 1'b1; start = 1'b0;
    core_success = '0; core_total_failure = '0; core_key = '0;
    @(negedge clk);
    step();
    step();
    check_value("rst_core_reset", 32'(core_reset), 32'd1);
    check_value("rst_cycles", cycles, 32'd0);
    reset = 1'b0;
    step();

    // 1: single winner on core 2
    launch();
    check_value("t1_released", 32'(core_reset), 32'd0);
    core_key[2*KW +: KW] = 24'h000A5C;
    core_success = 4'b0100;
    step();
    check_value("t1_found", 32'(found), 32'd1);
    check_value("t1_key", 32'(found_key), 32'h000A5C);
    check_value("t1_idx", 32'(winner_idx), 32'd2);
    check_value("t1_stop", 32'(stop), 32'd1);
    core_success = '0;
    step();

    // 2: cores 1 and 3 together, lowest wins
    launch();
    repeat (3) step();
    random_keys();
    core_success = 4'b1010;
    step();
    check_value("t2_idx", 32'(winner_idx), 32'd1);
    check_value("t2_key", 32'(found_key), 32'(core_key[KW +: KW]));
    core_success = '0;
    step();

    // 3: staggered failures
    launch();
    for (int c = 0; c < NC; c++) begin
      core_total_failure[c] = 1'b1;
      repeat (10) step();
      if (c < NC - 1) check_value("t3_not_yet", 32'(all_failed), 32'd0);
    end
    check_value("t3_failed", 32'(all_failed), 32'd1);
    check_value("t3_found", 32'(found), 32'd0);
    core_total_failure = '0;

    // 4: last failure coincides with a success
    launch();
    core_total_failure = 4'b0111;
    repeat (5) step();
    random_keys();
    core_total_failure = 4'b1111;
    core_success = 4'b0001;
    step();
    check_value("t4_found", 32'(found), 32'd1);
    check_value("t4_idx", 32'(winner_idx), 32'd0);
    check_value("t4_failed", 32'(all_failed), 32'd0);
    core_total_failure = '0; core_success = '0;

    // 5: stale success during launch is ignored; cycles measures dwell
    core_success = 4'b0100;
    launch();
    check_value("t5_ignored", 32'(found), 32'd0);
    core_success = '0;
    d = $urandom_range(2, 20);
    repeat (d) step();
    random_keys();
    core_success = 4'b0010;
    step();
    check_value("t5_found", 32'(found), 32'd1);
    check_value("t5_cycles", cycles, 32'(d + 1));
    core_success = '0;

    // 6: reset mid-search, then relaunch
    launch();
    repeat (5) step();
    reset = 1'b1;
    step();
    check_value("t6_busy", 32'(busy), 32'd0);
    check_value("t6_stop", 32'(stop), 32'd1);
    check_value("t6_cycles", cycles, 32'd0);
    reset = 1'b0;
    repeat (3) step();
    start = 1'b1;
    step();
    start = 1'b0;
    check_value("t6_relaunch_busy", 32'(busy), 32'd1);
    check_value("t6_relaunch_cycles", cycles, 32'd0);

    // Randomized traffic including restarts over results and mid-run resets
    repeat (500) begin
      reset = ($urandom_range(0, 99) == 0);
      start = ($urandom_range(0, 19) == 0);
      for (int i = 0; i < NC; i++) begin
        core_success[i]       = ($urandom_range(0, 29) == 0);
        core_total_failure[i] = ($urandom_range(0, 7) == 0);
      end
      random_keys();
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
